// File: rtl/cpu_sequencer_if.sv
// Signal bundle between the instruction sequencer and its datapath/test driver:
// decode inputs, memory handshake, phase indication and datapath strobes.
interface cpu_sequencer_if #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero;
    logic                mem_ready;
    logic                resume;
    logic [2:0]          phase;
    logic                sel;
    logic                rd;
    logic                ld_ir;
    logic                inc_pc;
    logic                halt;
    logic                ld_pc;
    logic                data_e;
    logic                ld_ac;
    logic                wr;
    logic                halted;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        output opcode, zero, mem_ready, resume,
        input  phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
        input  halted, instr_count
    );

    modport slave (
        input  opcode, zero, mem_ready, resume,
        output phase, sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
        output halted, instr_count
    );
endinterface

// File: rtl/cpu_sequencer.sv
// 8-phase fetch/execute control sequencer with halt/resume and a saturating
// retired-instruction counter. Define SEQ_WAIT_STATE_EN to enable memory wait states.
module cpu_sequencer #(
    parameter int OPCODE_W = 3,
    parameter int CNT_W    = 16
) (
    input logic            clk,
    input logic            rst,
    cpu_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    phase_e           phase_q, phase_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Any opcode bit above the 3-bit field turns the instruction into a NOP.
    logic [OPCODE_W-1:0] op_hi;
    logic                nop;
    logic                is_hlt, is_skz, is_sto, is_jmp, is_alu;
    logic                stall;

    assign op_hi  = bus.opcode >> 3;
    assign nop    = (op_hi != '0);
    assign is_hlt = ~nop & (bus.opcode[2:0] == 3'd0);
    assign is_skz = ~nop & (bus.opcode[2:0] == 3'd1);
    assign is_alu = ~nop & (bus.opcode[2:0] >= 3'd2) & (bus.opcode[2:0] <= 3'd5);
    assign is_sto = ~nop & (bus.opcode[2:0] == 3'd6);
    assign is_jmp = ~nop & (bus.opcode[2:0] == 3'd7);

`ifdef SEQ_WAIT_STATE_EN
    // Stall only where memory is actually being read.
    assign stall = ~bus.mem_ready &
                   ((phase_q == INST_FETCH) | ((phase_q == OP_FETCH) & is_alu));
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign stall            = 1'b0;
`endif

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.halt   = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.data_e = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        if (halted_q) begin
            bus.halt = 1'b1;
        end else begin
            case (phase_q)
                INST_ADDR: bus.sel = 1'b1;
                INST_FETCH: begin
                    bus.sel = 1'b1;
                    bus.rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    bus.sel   = 1'b1;
                    bus.rd    = 1'b1;
                    bus.ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    bus.inc_pc = 1'b1;
                    bus.halt   = is_hlt;
                end
                OP_FETCH: bus.rd = is_alu;
                ALU_OP: begin
                    bus.rd     = is_alu;
                    bus.inc_pc = is_skz & bus.zero;
                    bus.ld_pc  = is_jmp;
                    bus.data_e = is_sto;
                end
                STORE: begin
                    bus.rd     = is_alu;
                    bus.ld_ac  = is_alu;
                    bus.ld_pc  = is_jmp;
                    bus.wr     = is_sto;
                    bus.data_e = is_sto;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        phase_d  = phase_q;
        halted_d = halted_q;
        cnt_d    = cnt_q;
        if (halted_q) begin
            if (bus.resume) begin
                halted_d = 1'b0;
                phase_d  = OP_FETCH;
            end
        end else if ((phase_q == OP_ADDR) && is_hlt) begin
            halted_d = 1'b1;
        end else if (!stall) begin
            phase_d = phase_e'(phase_q + 3'd1);
            if ((phase_q == STORE) && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.halted      = halted_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios followed by random
// traffic, all compared against an integer-level reference model of the sequencer.
module tb_cpu_sequencer;
    localparam int OPCODE_W = 4;
    localparam int CNT_W    = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
`ifdef SEQ_WAIT_STATE_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    cpu_sequencer_if #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) bus ();
    cpu_sequencer #(.OPCODE_W(OPCODE_W), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_phase;
    bit m_halted;
    int m_cnt;
    bit m_valid;

    // Observation counters for scenario checks
    int seen_wr, seen_exec, n_inc, n_ldac, n_ldac_p7, n_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
    function automatic logic [8:0] exp_strobes(int ph, bit hd, int op, bit z);
        logic [8:0] s;
        bit hlt, skz, alu, sto, jmp;
        hlt = (op == 0);
        skz = (op == 1);
        alu = (op >= 2) && (op <= 5);
        sto = (op == 6);
        jmp = (op == 7);
        s = '0;
        if (hd) return 9'b0_0001_0000;
        case (ph)
            0: s[8] = 1'b1;
            1: s[8:7] = 2'b11;
            2, 3: s[8:6] = 3'b111;
            4: begin s[5] = 1'b1; s[4] = hlt; end
            5: s[7] = alu;
            6: begin s[7] = alu; s[5] = skz & z; s[3] = jmp; s[2] = sto; end
            7: begin s[7] = alu; s[1] = alu; s[3] = jmp; s[2] = sto; s[0] = sto; end
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic model_step(input bit r, input int op, input bit res, input bit mr);
        bit waiting;
        if (r) begin
            m_phase  = 0;
            m_halted = 0;
            m_cnt    = 0;
            m_valid  = 1;
            return;
        end
        if (!m_valid) return;
        waiting = WAIT_EN && !mr && (m_phase == 1 || (m_phase == 5 && op >= 2 && op <= 5));
        if (m_halted) begin
            if (res) begin
                m_halted = 0;
                m_phase  = 5;
            end
        end else if (m_phase == 4 && op == 0) begin
            m_halted = 1;
        end else if (!waiting) begin
            if (m_phase == 7) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_phase = (m_phase + 1) % 8;
        end
    endtask

    task automatic cycle(input bit r, input int op, input bit z, input bit res, input bit mr);
        logic [8:0] obs;
        @(negedge clk);
        rst           = r;
        bus.opcode    = OPCODE_W'(op);
        bus.zero      = z;
        bus.resume    = res;
        bus.mem_ready = mr;
        #1;
        obs = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
               bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
        seen_wr   += int'(bus.wr);
        seen_exec += int'(bus.ld_ac | bus.ld_pc | bus.wr | bus.data_e);
        n_inc     += int'(bus.inc_pc);
        n_ldac    += int'(bus.ld_ac);
        n_ldac_p7 += int'(bus.ld_ac && bus.phase == 3'd7);
        n_rd      += int'(bus.rd);
        if (m_valid) begin
            chk("phase", 32'(bus.phase), m_phase);
            chk("halted", 32'(bus.halted), 32'(m_halted));
            chk("instr_count", 32'(bus.instr_count), m_cnt);
            chk("strobes", 32'(obs), 32'(exp_strobes(m_phase, m_halted, op, z)));
        end
        model_step(r, op, res, mr);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        seen_wr = 0; seen_exec = 0; n_inc = 0; n_ldac = 0; n_ldac_p7 = 0; n_rd = 0;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.resume = 1'b0;
        bus.mem_ready = 1'b1;
        m_valid = 0; m_phase = 0; m_halted = 0; m_cnt = 0;
        clear_obs();

        // Reset, then one ADD instruction
        cycle(1, 2, 0, 1, 1);
        settle();
        chk("reset_phase", 32'(bus.phase), 0);
        chk("reset_sel", 32'({bus.sel, bus.rd, bus.wr, bus.halt}), 32'h8);
        clear_obs();
        for (int i = 0; i < 8; i++) cycle(0, 2, i[0], 0, 1);
        settle();
        chk("add_count", 32'(bus.instr_count), 1);
        chk("add_ldac_once", n_ldac, 1);
        chk("add_ldac_p7", n_ldac_p7, 1);

        // SKZ with zero set, then clear
        clear_obs();
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 1);
        chk("skz_zero1_inc", n_inc, 2);
        clear_obs();
        for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 1);
        chk("skz_zero0_inc", n_inc, 1);

        // HLT: park, hold for 10 cycles, resume
        for (int i = 0; i < 8 && !m_halted; i++) cycle(0, 0, 0, 0, 1);
        settle();
        chk("hlt_halted", 32'(bus.halted), 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, i[0], 0, i[1]);
        chk("hlt_hold_phase", 32'(bus.phase), 4);
        cycle(0, 0, 0, 1, 1);
        settle();
        chk("resume_phase", 32'(bus.phase), 5);
        chk("resume_halted", 32'(bus.halted), 0);
        for (int i = 0; i < 8 && m_phase != 0; i++) cycle(0, 0, 0, 1, 1);

        // NOP opcode with extra high bit
        clear_obs();
        for (int i = 0; i < 8; i++) cycle(0, 9, 1, 0, 1);
        chk("nop_exec_strobes", seen_exec, 0);
        chk("nop_inc", n_inc, 1);

        // Five instructions saturate a 2-bit counter
        for (int i = 0; i < 40; i++) cycle(0, 3, 0, 0, 1);
        settle();
        chk("count_saturated", 32'(bus.instr_count), 3);

        // Reset in phase 6 of STO abandons the store
        clear_obs();
        for (int i = 0; i < 8 && m_phase != 6; i++) cycle(0, 6, 0, 0, 1);
        cycle(1, 6, 0, 1, 1);
        settle();
        chk("sto_rst_phase", 32'(bus.phase), 0);
        chk("sto_rst_count", 32'(bus.instr_count), 0);
        cycle(0, 6, 0, 0, 1);
        chk("sto_rst_no_wr", seen_wr, 0);

        // LDA with memory not ready during operand fetch
        cycle(1, 5, 0, 0, 1);
        cyc = 0;
`ifdef SEQ_WAIT_STATE_EN
        while (m_phase != 5 && cyc < 8) begin cycle(0, 5, 0, 0, 1); cyc++; end
        clear_obs();
        for (int i = 0; i < 3; i++) begin cycle(0, 5, 0, 0, 0); cyc++; end
        chk("lda_wait_rd", n_rd, 3);
        chk("lda_wait_phase", 32'(bus.phase), 5);
        do begin cycle(0, 5, 0, 0, 1); cyc++; end while (m_phase != 0 && cyc < 20);
        chk("lda_wait_cycles", cyc, 11);
`else
        for (int i = 0; i < 8; i++) begin cycle(0, 5, 0, 0, 0); cyc++; end
        settle();
        chk("lda_nowait_phase", 32'(bus.phase), 0);
        chk("lda_nowait_cycles", cyc, 8);
`endif

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            int op;
            op = $urandom_range(1, 15);
            if ($urandom_range(0, 9) == 0) op = 0;
            cycle($urandom_range(0, 63) == 0, op, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 3, opcode field width; SHALL be >= 3.
REQ-002 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 opcode  input  OPCODE_W  instruction opcode from IR.
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 mem_ready  input  1  memory read-data valid; used only with the configuration macro defined.
REQ-008 resume  input  1  restart request while halted.
REQ-009 phase  output  3  current phase, 0..7.
REQ-010 sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr  output  1 each  datapath strobes.
REQ-011 halted  output  1  sequencer parked in halt.
REQ-012 instr_count  output  CNT_W  retired-instruction count.

Function
REQ-013 Phases SHALL be INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
REQ-014 Decode: opcode 0..7 = HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP; opcode >= 8 SHALL decode as NOP (all opcode-dependent terms 0); ALUOP = ADD|AND|XOR|LDA.
REQ-015 Strobes SHALL be combinational from phase, decode and zero; strobes not listed below are 0:
 - 0: sel.  1: sel, rd.  2,3: sel, rd, ld_ir.
 - 4: inc_pc=1, halt=HLT.  5: rd=ALUOP.
 - 6: rd=ALUOP, inc_pc=SKZ&zero, ld_pc=JMP, data_e=STO.
 - 7: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
REQ-016 With halted=1, strobes SHALL be forced to 0 except halt=1.
REQ-017 Phase SHALL advance by 1 per cycle, wrapping 7->0, unless stalled or halted.
REQ-018 At phase 4 with HLT decoded, next edge SHALL set halted=1 and hold phase at 4.
REQ-019 While halted, resume=1 SHALL clear halted and set phase to 5 on the same edge; resume with halted=0 SHALL be ignored.
REQ-020 instr_count SHALL increment on each 7->0 wrap and saturate at all-ones; no increment while stalled or halted.
REQ-021 zero is sampled combinationally in phase 6 only; changes elsewhere SHALL have no effect.

Reset
REQ-022 rst=1 SHALL on the next edge set phase=0, halted=0, instr_count=0, overriding resume, stall and halt; strobes then SHALL be sel=1, all others 0.
REQ-023 Reset asserted mid-instruction or mid-stall SHALL abandon the instruction; no strobe beyond the phase-0 pattern in the following cycle.

Configuration
REQ-024 Macro SEQ_WAIT_STATE_EN defined: in phase 1, and in phase 5 when rd=1, phase SHALL hold while mem_ready=0 with strobes unchanged, and advance on the first edge with mem_ready=1.
REQ-025 SEQ_WAIT_STATE_EN undefined: mem_ready SHALL be ignored; no stalls; timing exactly 8 cycles per non-halting instruction.

Verification
REQ-026 rst 1 cycle, opcode=2 (ADD), macro off -> phase 0..7 over 8 cycles, ld_ac=1 only in phase 7, instr_count=1 after wrap.
REQ-027 opcode=1 (SKZ), zero=1 -> inc_pc=1 in phases 4 and 6; zero=0 -> inc_pc=1 in phase 4 only.
REQ-028 opcode=0 (HLT) -> halt=1 in phase 4, halted=1 next cycle, phase stays 4 for 10 cycles; resume=1 -> phase=5, halted=0 next cycle.
REQ-029 Macro on, opcode=5 (LDA), mem_ready=0 for 3 cycles in phase 5 -> phase 5 held 4 cycles with rd=1; instruction takes 11 cycles.
REQ-030 OPCODE_W=4, opcode=9 -> NOP: only fetch strobes and phase-4 inc_pc; ld_ac, ld_pc, wr, data_e never 1.
REQ-031 CNT_W=2, run 5 instructions -> instr_count=3 held; rst asserted in phase 6 of STO -> wr never 1, phase=0 next cycle.
